// File: rtl/forward_pkg.sv
// Shared constants and helpers for the forwarding history and its consumers.
// Slot numbering: slot i*D+j is table i, age j, with j=0 the newest.
package forward_pkg;

  localparam int FORWARD_DEPTH_DEFAULT = 2;

  // Width of a counter that must hold 0..d inclusive.
  function automatic int cnt_width(input int d);
    return (d < 1) ? 1 : $clog2(d + 1);
  endfunction

  function automatic int slot_idx(input int i, input int j, input int d);
    return i * d + j;
  endfunction

endpackage

// File: rtl/forward_history_lane.sv
// One table's write history: a D-deep shift register advanced on clk_en, plus an occupancy count.
// Registered outputs; a write shows at age 0 one enabled edge after issue. There is no backpressure, and clk_en=0 freezes the lane.
module forward_history_lane
  import forward_pkg::*;
#(
  parameter int DATA_WIDTH           = 4,
  parameter int KEY_WIDTH            = 2,
  parameter int HASH_ADR_WIDTH       = 2,
  parameter int SHIFT_HASH_ADR_WIDTH = 2,
  parameter int FORWARD_DEPTH        = FORWARD_DEPTH_DEFAULT,
  parameter int HAS_SHIFT            = 1,
  localparam int CW = cnt_width(FORWARD_DEPTH)
) (
  input  logic                                          clk,
  input  logic                                          reset,
  input  logic                                          clk_en,
  input  logic                                          flush,
  input  logic                                          wr_en,
  input  logic [HASH_ADR_WIDTH-1:0]                     wr_hash_adr,
  input  logic [KEY_WIDTH-1:0]                          wr_key,
  input  logic [DATA_WIDTH-1:0]                         wr_data,
  input  logic                                          wr_valid,
  input  logic [SHIFT_HASH_ADR_WIDTH-1:0]               wr_shift_adr,
  input  logic                                          wr_shift_valid,
  output logic [FORWARD_DEPTH-1:0]                      updated,
  output logic [FORWARD_DEPTH*HASH_ADR_WIDTH-1:0]       hash_adr,
  output logic [FORWARD_DEPTH*KEY_WIDTH-1:0]            key,
  output logic [FORWARD_DEPTH*DATA_WIDTH-1:0]           data,
  output logic [FORWARD_DEPTH-1:0]                      valid,
  output logic [FORWARD_DEPTH*SHIFT_HASH_ADR_WIDTH-1:0] shift_hash_adr,
  output logic [FORWARD_DEPTH-1:0]                      shift_valid,
  output logic [CW-1:0]                                 pending_cnt
);

  localparam int D  = FORWARD_DEPTH;
  localparam int AW = HASH_ADR_WIDTH;
  localparam int KW = KEY_WIDTH;
  localparam int DW = DATA_WIDTH;
  localparam int SW = SHIFT_HASH_ADR_WIDTH;

  // A non-write cycle enters the history as an all-zero slot.
  logic [AW-1:0] s0_adr;
  logic [KW-1:0] s0_key;
  logic [DW-1:0] s0_data;
  logic          s0_valid;
  logic [SW-1:0] s0_sadr;
  logic          s0_sval;

  assign s0_adr   = wr_en ? wr_hash_adr : '0;
  assign s0_key   = wr_en ? wr_key : '0;
  assign s0_data  = wr_en ? wr_data : '0;
  assign s0_valid = wr_en & wr_valid;
  assign s0_sadr  = (wr_en && HAS_SHIFT != 0) ? wr_shift_adr : '0;
  assign s0_sval  = wr_en & wr_shift_valid & (HAS_SHIFT != 0);

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      updated        <= '0;
      hash_adr       <= '0;
      key            <= '0;
      data           <= '0;
      valid          <= '0;
      shift_hash_adr <= '0;
      shift_valid    <= '0;
    end else if (clk_en) begin
      for (int j = 1; j < D; j++) begin
        updated[j]                <= updated[j-1];
        hash_adr[j*AW +: AW]      <= hash_adr[(j-1)*AW +: AW];
        key[j*KW +: KW]           <= key[(j-1)*KW +: KW];
        data[j*DW +: DW]          <= data[(j-1)*DW +: DW];
        valid[j]                  <= valid[j-1];
        shift_hash_adr[j*SW +: SW] <= shift_hash_adr[(j-1)*SW +: SW];
        shift_valid[j]            <= shift_valid[j-1];
      end
    end

    // A write coinciding with a flush already reached memory, so it still enters slot 0.
    if (!reset && clk_en) begin
      updated[0]          <= wr_en;
      hash_adr[0 +: AW]   <= s0_adr;
      key[0 +: KW]        <= s0_key;
      data[0 +: DW]       <= s0_data;
      valid[0]            <= s0_valid;
      shift_hash_adr[0 +: SW] <= s0_sadr;
      shift_valid[0]      <= s0_sval;
    end

    if (reset) begin
      pending_cnt <= '0;
    end else if (flush) begin
      pending_cnt <= CW'(wr_en & clk_en);
    end else if (clk_en) begin
      pending_cnt <= pending_cnt + CW'(wr_en) - CW'(updated[D-1]);
    end
  end

endmodule

// File: rtl/forward_history_recorder.sv
// Per-table write history feeding the cuckoo read-stage forwarding logic; one lane per table, flattened to slot i*D+j.
// Outputs are purely registered with one enabled edge from write to age 0, and clk_en=0 stalls every lane.
module forward_history_recorder
  import forward_pkg::*;
#(
  parameter int DATA_WIDTH           = 4,
  parameter int KEY_WIDTH            = 2,
  parameter int HASH_ADR_WIDTH       = 2,
  parameter int SHIFT_HASH_ADR_WIDTH = 2,
  parameter int NUMBER_OF_TABLES     = 4,
  parameter int FORWARD_DEPTH        = FORWARD_DEPTH_DEFAULT,
  localparam int N  = NUMBER_OF_TABLES,
  localparam int D  = FORWARD_DEPTH,
  localparam int CW = cnt_width(FORWARD_DEPTH)
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic                                  clk_en,
  input  logic                                  flush_i,
  input  logic [N-1:0]                          wr_en_i,
  input  logic [N*HASH_ADR_WIDTH-1:0]           wr_hash_adr_i,
  input  logic [N*DATA_WIDTH-1:0]               wr_data_i,
  input  logic [N*KEY_WIDTH-1:0]                wr_key_i,
  input  logic [N-1:0]                          wr_valid_i,
  input  logic [(N-1)*SHIFT_HASH_ADR_WIDTH-1:0] wr_shift_adr_i,
  input  logic [N-2:0]                          wr_shift_valid_i,
  output logic [N*D*HASH_ADR_WIDTH-1:0]         forward_hash_adr_o,
  output logic [N*D*DATA_WIDTH-1:0]             forward_data_o,
  output logic [N*D*KEY_WIDTH-1:0]              forward_key_o,
  output logic [N*D-1:0]                        forward_valid_o,
  output logic [N*D-1:0]                        forward_updated_mem_o,
  output logic [(N-1)*D*SHIFT_HASH_ADR_WIDTH-1:0] forward_shift_hash_adr_o,
  output logic [(N-1)*D-1:0]                    forward_shift_valid_o,
  output logic [N*CW-1:0]                       pending_cnt_o
);

  localparam int AW = HASH_ADR_WIDTH;
  localparam int KW = KEY_WIDTH;
  localparam int DW = DATA_WIDTH;
  localparam int SW = SHIFT_HASH_ADR_WIDTH;

  for (genvar i = 0; i < N; i++) begin : g_lane
    localparam int S0 = slot_idx(i, 0, D);
    localparam int HS = (i < N - 1) ? 1 : 0;

    logic [SW-1:0]   lane_sadr_in;
    logic            lane_sval_in;
    logic [D*SW-1:0] lane_sadr;
    logic [D-1:0]    lane_sval;

    // The last table has no shift table behind it, so its shift fields stay internal and zero.
    if (HS != 0) begin : g_shift
      assign lane_sadr_in = wr_shift_adr_i[i*SW +: SW];
      assign lane_sval_in = wr_shift_valid_i[i];
      assign forward_shift_hash_adr_o[S0*SW +: D*SW] = lane_sadr;
      assign forward_shift_valid_o[S0 +: D]          = lane_sval;
    end else begin : g_no_shift
      assign lane_sadr_in = '0;
      assign lane_sval_in = 1'b0;
    end

    forward_history_lane #(
      .DATA_WIDTH          (DW),
      .KEY_WIDTH           (KW),
      .HASH_ADR_WIDTH      (AW),
      .SHIFT_HASH_ADR_WIDTH(SW),
      .FORWARD_DEPTH       (D),
      .HAS_SHIFT           (HS)
    ) u_lane (
      .clk           (clk),
      .reset         (reset),
      .clk_en        (clk_en),
      .flush         (flush_i),
      .wr_en         (wr_en_i[i]),
      .wr_hash_adr   (wr_hash_adr_i[i*AW +: AW]),
      .wr_key        (wr_key_i[i*KW +: KW]),
      .wr_data       (wr_data_i[i*DW +: DW]),
      .wr_valid      (wr_valid_i[i]),
      .wr_shift_adr  (lane_sadr_in),
      .wr_shift_valid(lane_sval_in),
      .updated       (forward_updated_mem_o[S0 +: D]),
      .hash_adr      (forward_hash_adr_o[S0*AW +: D*AW]),
      .key           (forward_key_o[S0*KW +: D*KW]),
      .data          (forward_data_o[S0*DW +: D*DW]),
      .valid         (forward_valid_o[S0 +: D]),
      .shift_hash_adr(lane_sadr),
      .shift_valid   (lane_sval),
      .pending_cnt   (pending_cnt_o[i*CW +: CW])
    );
  end

endmodule

// File: tb/tb_forward_history_recorder.sv
// Directed bench for forward_history_recorder (N=4, D=2): stimulus pushes hand-computed slot
// expectations tagged with the edge they follow; a monitor pops and compares after that edge.
module tb_forward_history_recorder;
  import forward_pkg::*;

  localparam int N  = 4;
  localparam int D  = 2;
  localparam int DW = 4;
  localparam int KW = 2;
  localparam int AW = 2;
  localparam int SW = 2;
  localparam int CW = cnt_width(D);

  logic                clk;
  logic                reset;
  logic                clk_en;
  logic                flush_i;
  logic [N-1:0]        wr_en_i;
  logic [N*AW-1:0]     wr_hash_adr_i;
  logic [N*DW-1:0]     wr_data_i;
  logic [N*KW-1:0]     wr_key_i;
  logic [N-1:0]        wr_valid_i;
  logic [(N-1)*SW-1:0] wr_shift_adr_i;
  logic [N-2:0]        wr_shift_valid_i;
  logic [N*D*AW-1:0]   forward_hash_adr_o;
  logic [N*D*DW-1:0]   forward_data_o;
  logic [N*D*KW-1:0]   forward_key_o;
  logic [N*D-1:0]      forward_valid_o;
  logic [N*D-1:0]      forward_updated_mem_o;
  logic [(N-1)*D*SW-1:0] forward_shift_hash_adr_o;
  logic [(N-1)*D-1:0]  forward_shift_valid_o;
  logic [N*CW-1:0]     pending_cnt_o;

  forward_history_recorder #(
    .DATA_WIDTH(DW), .KEY_WIDTH(KW), .HASH_ADR_WIDTH(AW),
    .SHIFT_HASH_ADR_WIDTH(SW), .NUMBER_OF_TABLES(N), .FORWARD_DEPTH(D)
  ) dut (
    .clk                     (clk),
    .reset                   (reset),
    .clk_en                  (clk_en),
    .flush_i                 (flush_i),
    .wr_en_i                 (wr_en_i),
    .wr_hash_adr_i           (wr_hash_adr_i),
    .wr_data_i               (wr_data_i),
    .wr_key_i                (wr_key_i),
    .wr_valid_i              (wr_valid_i),
    .wr_shift_adr_i          (wr_shift_adr_i),
    .wr_shift_valid_i        (wr_shift_valid_i),
    .forward_hash_adr_o      (forward_hash_adr_o),
    .forward_data_o          (forward_data_o),
    .forward_key_o           (forward_key_o),
    .forward_valid_o         (forward_valid_o),
    .forward_updated_mem_o   (forward_updated_mem_o),
    .forward_shift_hash_adr_o(forward_shift_hash_adr_o),
    .forward_shift_valid_o   (forward_shift_valid_o),
    .pending_cnt_o           (pending_cnt_o)
  );

  typedef struct {
    int cyc;
    int kind;
    int i;
    int j;
    int val;
  } exp_t;

  exp_t q[$];
  int   cyc    = 0;
  int   n_chk  = 0;
  int   n_pass = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic string kname(input int k);
    case (k)
      0: return "adr";
      1: return "key";
      2: return "data";
      3: return "valid";
      4: return "updated";
      5: return "shift_adr";
      6: return "shift_valid";
      default: return "pending_cnt";
    endcase
  endfunction

  function automatic int dut_val(input int k, input int i, input int j);
    int s;
    s = i * D + j;
    case (k)
      0: return int'(forward_hash_adr_o[s*AW +: AW]);
      1: return int'(forward_key_o[s*KW +: KW]);
      2: return int'(forward_data_o[s*DW +: DW]);
      3: return int'(forward_valid_o[s]);
      4: return int'(forward_updated_mem_o[s]);
      5: return int'(forward_shift_hash_adr_o[s*SW +: SW]);
      6: return int'(forward_shift_valid_o[s]);
      default: return int'(pending_cnt_o[i*CW +: CW]);
    endcase
  endfunction

  // Monitor: sample #1 after each rising edge and retire every expectation due by now.
  initial begin
    exp_t e;
    int   act;
    forever begin
      @(posedge clk);
      #1;
      while (q.size() > 0 && q[0].cyc <= cyc) begin
        e   = q.pop_front();
        act = dut_val(e.kind, e.i, e.j);
        n_chk++;
        if (e.cyc != cyc || act != e.val)
          $display("FAIL %s t%0d j%0d edge%0d: got %0d, expected %0d", kname(e.kind), e.i, e.j, e.cyc, act, e.val);
        else
          n_pass++;
      end
    end
  end

  task automatic expect_v(input int k, input int i, input int j, input int v);
    exp_t e;
    e = '{cyc + 1, k, i, j, v};
    q.push_back(e);
  endtask

  task automatic exp_cnt(input int i, input int v);
    expect_v(7, i, 0, v);
  endtask

  task automatic exp_slot(input int i, input int j, input int upd, input int adr, input int key,
                          input int data, input int valid, input int sadr, input int sval);
    expect_v(4, i, j, upd);
    expect_v(0, i, j, adr);
    expect_v(1, i, j, key);
    expect_v(2, i, j, data);
    expect_v(3, i, j, valid);
    if (i < N - 1) begin
      expect_v(5, i, j, sadr);
      expect_v(6, i, j, sval);
    end
  endtask

  task automatic exp_empty(input int i, input int j);
    exp_slot(i, j, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic exp_all_zero();
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < D; j++) exp_empty(i, j);
      exp_cnt(i, 0);
    end
  endtask

  task automatic set_wr(input int i, input int adr, input int key, input int data,
                        input int valid, input int sadr, input int sval);
    wr_en_i[i]                = 1'b1;
    wr_hash_adr_i[i*AW +: AW] = AW'(adr);
    wr_key_i[i*KW +: KW]      = KW'(key);
    wr_data_i[i*DW +: DW]     = DW'(data);
    wr_valid_i[i]             = 1'(valid);
    if (i < N - 1) begin
      wr_shift_adr_i[i*SW +: SW] = SW'(sadr);
      wr_shift_valid_i[i]        = 1'(sval);
    end
  endtask

  task automatic clr_wr();
    wr_en_i          = '0;
    wr_hash_adr_i    = '0;
    wr_key_i         = '0;
    wr_data_i        = '0;
    wr_valid_i       = '0;
    wr_shift_adr_i   = '0;
    wr_shift_valid_i = '0;
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached with %0d checks outstanding", q.size());
    $fatal(1, "watchdog");
  end

  initial begin
    reset   = 1'b1;
    clk_en  = 1'b1;
    flush_i = 1'b0;
    clr_wr();
    for (int i = 0; i < N; i++) set_wr(i, 3, 3, 15, 1, 3, 1);

    // Reset dominates even with every table writing.
    exp_all_zero(); step();
    exp_all_zero(); step();
    reset = 1'b0;
    clr_wr();

    // Single write propagates through both ages and leaves.
    set_wr(1, 2, 1, 'hA, 1, 0, 0);
    exp_slot(1, 0, 1, 2, 1, 10, 1, 0, 0); exp_cnt(1, 1); step();
    clr_wr();
    exp_slot(1, 1, 1, 2, 1, 10, 1, 0, 0); exp_empty(1, 0); exp_cnt(1, 1); step();
    exp_empty(1, 1); exp_cnt(1, 0); step();

    // Stall: clk_en=0 holds the entry and ignores the write strobe.
    set_wr(0, 1, 2, 3, 1, 2, 1);
    exp_slot(0, 0, 1, 1, 2, 3, 1, 2, 1); exp_cnt(0, 1); step();
    clk_en = 1'b0;
    set_wr(0, 3, 3, 15, 0, 1, 0);
    for (int k = 0; k < 3; k++) begin
      exp_slot(0, 0, 1, 1, 2, 3, 1, 2, 1); exp_empty(0, 1); exp_cnt(0, 1); step();
    end
    clk_en = 1'b1;
    clr_wr();
    exp_slot(0, 1, 1, 1, 2, 3, 1, 2, 1); exp_empty(0, 0); exp_cnt(0, 1); step();
    exp_empty(0, 1); exp_cnt(0, 0); step();

    // Flush with a concurrent write keeps only that write.
    set_wr(3, 1, 0, 7, 1, 0, 0);
    exp_cnt(3, 1); step();
    set_wr(3, 2, 1, 8, 1, 0, 0);
    exp_slot(3, 0, 1, 2, 1, 8, 1, 0, 0); exp_slot(3, 1, 1, 1, 0, 7, 1, 0, 0); exp_cnt(3, 2); step();
    flush_i = 1'b1;
    set_wr(3, 3, 3, 9, 1, 0, 0);
    exp_slot(3, 0, 1, 3, 3, 9, 1, 0, 0); exp_empty(3, 1); exp_cnt(3, 1); step();
    clk_en = 1'b0;
    exp_all_zero(); step();
    flush_i = 1'b0;
    clk_en  = 1'b1;
    clr_wr();

    // Delete with shift fields on table 2; table 3 records no shift.
    set_wr(2, 1, 2, 5, 0, 1, 1);
    set_wr(3, 2, 1, 4, 1, 0, 0);
    exp_slot(2, 0, 1, 1, 2, 5, 0, 1, 1); exp_cnt(2, 1);
    exp_slot(3, 0, 1, 2, 1, 4, 1, 0, 0); exp_cnt(3, 1); step();
    clr_wr();

    // Back-to-back duplicate addresses are kept in age order.
    set_wr(0, 1, 0, 5, 1, 0, 0);
    exp_slot(0, 0, 1, 1, 0, 5, 1, 0, 0); exp_slot(2, 1, 1, 1, 2, 5, 0, 1, 1);
    exp_cnt(0, 1); exp_cnt(2, 1); step();
    set_wr(0, 1, 0, 6, 1, 0, 0);
    exp_slot(0, 0, 1, 1, 0, 6, 1, 0, 0); exp_slot(0, 1, 1, 1, 0, 5, 1, 0, 0);
    exp_cnt(0, 2); exp_cnt(2, 0); step();

    // Mid-stream reset drops everything in one edge.
    reset = 1'b1;
    set_wr(1, 1, 1, 1, 1, 1, 1);
    exp_all_zero(); step();
    reset = 1'b0;
    clr_wr();
    exp_all_zero(); step();

    repeat (2) step();
    if (q.size() != 0) begin
      $display("FAIL drain: got %0d unchecked expectations, expected 0", q.size());
      n_chk += q.size();
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/forward_history_recorder.md
# forward_history_recorder

Per-table write history for the cuckoo hash pipeline. The block records every memory write issued to each hash table over the last FORWARD_DEPTH enabled cycles and presents them as forward entries (address, key, data, valid, shift address). Read stages consume these entries to replace stale memory read data. It sits between the table write port and the forwarding/position-update logic, and produces the data that logic consumes.

## Interface
- DATA_WIDTH, 4, data field width
- KEY_WIDTH, 2, key field width
- HASH_ADR_WIDTH, 2, table address width
- SHIFT_HASH_ADR_WIDTH, 2, shift-table address width
- NUMBER_OF_TABLES, 4, number of hash tables (N); shift fields exist for tables 0..N-2
- FORWARD_DEPTH, 2, history slots per table (D ≥ 1)

Ports:
- clk  in  1  clock; all state updates on its rising edge
- reset  in  1  synchronous, active-high
- clk_en  in  1  pipeline advance enable
- flush_i  in  1  clear all history
- wr_en_i  in  [N-1:0] x 1  a write to table i happens this cycle
- wr_hash_adr_i  in  [N-1:0] x HASH_ADR_WIDTH  write address
- wr_data_i / wr_key_i  in  [N-1:0] x DATA_WIDTH / KEY_WIDTH  written data and key
- wr_valid_i  in  [N-1:0] x 1  valid bit written to memory (0 = delete)
- wr_shift_adr_i  in  [N-2:0] x SHIFT_HASH_ADR_WIDTH  written shift address
- wr_shift_valid_i  in  [N-2:0] x 1  written shift valid
- forward_hash_adr_o, forward_data_o, forward_key_o, forward_valid_o  out  [N*D-1:0] x field width  slot fields
- forward_updated_mem_o  out  [N*D-1:0] x 1  slot holds a real write
- forward_shift_hash_adr_o, forward_shift_valid_o  out  [(N-1)*D-1:0] x field width
- pending_cnt_o  out  [N-1:0] x $clog2(D+1)  number of occupied slots per table

Slot index is i*D + j: table i, age j, with j=0 the newest.

## Operation
- Each table has a D-deep shift register of entries {updated, adr, key, data, valid, shift_adr, shift_valid}.
- On an edge with clk_en=1:
  - Slot j moves to slot j+1.
  - Slot D-1 is discarded.
  - Slot 0 loads the inputs with updated = wr_en_i[i].
  - If wr_en_i[i]=0, slot 0 loads all zeros.
- clk_en=0: all slots and counters hold, and wr_en_i is ignored.
- flush_i=1 clears every slot to zero regardless of clk_en. If clk_en=1 in the same cycle, slot 0 still loads the current write. The write has reached memory, so it must be forwarded.
- pending_cnt_o[i] next value = (updated bits after the edge), maintained incrementally:
  - +1 if a write enters.
  - −1 if an updated slot D-1 leaves.
  - After a flush, the value is wr_en_i[i]&clk_en.
- Duplicate addresses across slots are legal and are not merged. Consumers give priority to the lowest j.
- Shift fields are recorded only for tables 0..N-2.

## Timing
- Reset: every output is 0, all slots are cleared, and pending_cnt_o = 0. Reset overrides flush_i and clk_en.
- Latency: a write at edge t (clk_en=1) is visible at j=0 after t+1. It is at age j after j+1 consecutive enabled edges, and leaves after D+1.
- Outputs are purely registered, with no combinational path from input to output.
- Reset asserted mid-stream drops all history within one edge.

## Structure
- Package forward_pkg holds:
  - The default FORWARD_DEPTH constant.
  - A count-width function, clog2(D+1).
  - The slot-index helper i*D+j, shared with the consumer side.
- Sub-module forward_history_lane implements one table's shift register and counter. It takes a parameter HAS_SHIFT (0 for table N-1).
- The top level is a generate loop over the tables plus output flattening.

## Test plan
All cases use D=2 and N=4.
- Reset: assert reset for 2 cycles with wr_en_i=all 1s → all outputs 0 and pending_cnt_o=0 after the edge.
- Single write propagation: table 1 write adr=2, key=1, data=0xA, valid=1.
  - After the next edge: slot 1*2+0 holds the write and pending=1.
  - After the following edge: the write is at j=1.
  - After the third edge: it is gone and pending=0.
- Stall: write to table 0, then clk_en=0 for 3 cycles → the entry stays at j=0 and pending=1. It moves to j=1 only on the next enabled edge.
- Flush with write: slots full (pending=2), then flush_i=1 with clk_en=1 and a write adr=3 → after the edge only j=0 is updated, holding adr=3, and pending=1. Repeat with clk_en=0 → everything cleared and pending=0.
- Delete and shift: table 2 write valid=0 with shift_adr=1, shift_valid=1 → forward_valid_o=0, updated=1, and the shift fields recorded. Table 3 shows no shift outputs.
- Back-to-back duplicates: two consecutive writes to adr=1 on table 0 with data 5 then 6 → j=0 holds data=6, j=1 holds data=5, and pending=2.
